// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird VGA pipeline.
package flappy_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;
  localparam int POS_W    = 12;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    RESTART,
    RUN,
    HALT
  } state_e;

  typedef logic signed [POS_W-1:0] pos_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock regardless of game state.
module lfsr16
  import flappy_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;

  // Shift register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe obstacles: positions, respawn, per-pixel hit flag and score pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | pipes parked off-screen right, waiting for start
//   RESTART | one cycle: reload start positions and initial gaps
//   RUN     | pipes scroll left on frame_tick, halt freezes
//   HALT    | pipes frozen but still drawn, start restarts
module pipe_field
  import flappy_pkg::*;
#(
  parameter int          NUM_PIPES    = 3,
  parameter int          PIPE_WIDTH   = 52,
  parameter int          GAP_HEIGHT   = 120,
  parameter int          GAP_MIN      = 40,
  parameter int          GAP_INIT     = 180,
  parameter int          PIPE_SPACING = 220,
  parameter int          SCROLL_SPEED = 2,
  parameter int          BIRD_X       = 160,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               halt,
  output logic               pipe_color,
  output logic               score_pulse,
  output logic               running
);

  localparam pos_t PW       = pos_t'(PIPE_WIDTH);
  localparam pos_t X_WRAP   = pos_t'(-PIPE_WIDTH);
  localparam pos_t X_PITCH  = pos_t'(NUM_PIPES * PIPE_SPACING);
  localparam pos_t SCROLL   = pos_t'(SCROLL_SPEED);
  localparam pos_t BIRD     = pos_t'(BIRD_X);
  localparam logic [COORD_W-1:0] GAP_INIT_C = COORD_W'(GAP_INIT);
  localparam logic [COORD_W-1:0] GAP_MIN_C  = COORD_W'(GAP_MIN);
  localparam logic [COORD_W-1:0] H_LIM      = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM      = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W:0]   GAP_H_C    = (COORD_W+1)'(GAP_HEIGHT);

  // Gap must stay on screen even at the largest random offset.
  if (GAP_MIN + 255 + GAP_HEIGHT > V_ACTIVE || NUM_PIPES < 2 || NUM_PIPES > 4 ||
      LFSR_SEED == 16'h0000) begin : g_bad_params
    $error("pipe_field: illegal parameter combination");
  end

  state_e         state_q, state_d;
  logic           load_init, scroll_en;
  logic [15:0]    lfsr_w;
  logic           lfsr_unused;
  logic [NUM_PIPES-1:0] hit_w, score_w;
  logic           pipe_color_q, pipe_color_d;
  logic           score_q;
  pos_t           px;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr_w)
  );

  // Only the low byte feeds the gap offset.
  assign lfsr_unused = ^lfsr_w[15:8];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; halt takes priority over start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !halt) state_d = RESTART;
      RESTART: state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      HALT:    if (start && !halt) state_d = RESTART;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs; a cycle carrying start or halt never scrolls.
  always_comb begin
    running   = (state_q == RUN);
    load_init = (state_q == RESTART);
    scroll_en = (state_q == RUN) && frame_tick && !start && !halt;
  end

  assign px = $signed({2'b00, pixel_x});

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    localparam pos_t X_INIT = pos_t'(H_ACTIVE + i * PIPE_SPACING);

    pos_t               x_q, x_d, x_new;
    logic [COORD_W-1:0] gap_q, gap_d;
    logic [COORD_W:0]   gap_end;
    logic               wrap;

    // Scroll by one step, wrapping to the back of the queue with a fresh gap.
    always_comb begin
      x_new = x_q - SCROLL;
      wrap  = (x_new <= X_WRAP);
      x_d   = x_q;
      gap_d = gap_q;
      if (load_init) begin
        x_d   = X_INIT;
        gap_d = GAP_INIT_C;
      end else if (scroll_en) begin
        if (wrap) begin
          x_d   = x_new + X_PITCH;
          gap_d = GAP_MIN_C + COORD_W'(lfsr_w[7:0]);
        end else begin
          x_d = x_new;
        end
      end
    end

    // Pipe position and gap registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q   <= X_INIT;
        gap_q <= GAP_INIT_C;
      end else begin
        x_q   <= x_d;
        gap_q <= gap_d;
      end
    end

    // Right edge crosses the bird column on this step.
    assign score_w[i] = scroll_en && !wrap && (x_q + PW >= BIRD) && (x_new + PW < BIRD);

    assign gap_end  = {1'b0, gap_q} + GAP_H_C;
    assign hit_w[i] = (px >= x_q) && (px < x_q + PW) &&
                      ((pixel_y < gap_q) || ({1'b0, pixel_y} >= gap_end));
  end

  // Visible-area qualified hit test.
  always_comb begin
    pipe_color_d = (pixel_x < H_LIM) && (pixel_y < V_LIM) && (|hit_w);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_color_q <= 1'b0;
      score_q      <= 1'b0;
    end else begin
      pipe_color_q <= pipe_color_d;
      score_q      <= |score_w;
    end
  end

  assign pipe_color  = pipe_color_q;
  assign score_pulse = score_q;

endmodule

// File: tb/tb_pipe_field.sv
// Scoreboard bench for pipe_field with a behavioural game model.
module tb_pipe_field;

  localparam int NP    = 3;
  localparam int PW    = 52;
  localparam int GH    = 120;
  localparam int GMIN  = 40;
  localparam int GINIT = 180;
  localparam int SP    = 220;
  localparam int SS    = 2;
  localparam int BX    = 160;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, start, halt;
  logic [9:0] pixel_x, pixel_y;
  logic       pipe_color, score_pulse, running;

  always #5 clk = ~clk;

  pipe_field dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_tick  (frame_tick),
    .start       (start),
    .halt        (halt),
    .pipe_color  (pipe_color),
    .score_pulse (score_pulse),
    .running     (running)
  );

  typedef struct {
    bit color;
    bit score;
    bit run;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  typedef enum {M_IDLE, M_RESTART, M_RUN, M_HALT} mstate_e;
  mstate_e   ms;
  int        mx[NP];
  int        mg[NP];
  bit [15:0] ml;

  function automatic void m_load();
    for (int i = 0; i < NP; i++) begin
      mx[i] = 640 + i * SP;
      mg[i] = GINIT;
    end
  endfunction

  function automatic void m_reset();
    ms = M_IDLE;
    m_load();
    ml = 16'hACE1;
  endfunction

  function automatic bit m_color(int px, int py);
    if (px >= 640 || py >= 480) return 1'b0;
    for (int i = 0; i < NP; i++)
      if (px >= mx[i] && px < mx[i] + PW && (py < mg[i] || py >= mg[i] + GH)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string nm, logic got, bit exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
    end
  endtask

  function automatic void rnd_pix(output int px, output int py);
    if ($urandom_range(0, 9) < 8) begin
      px = $urandom_range(0, 700);
      py = $urandom_range(0, 500);
    end else begin
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 1023);
    end
  endfunction

  // Drive one clock's worth of inputs and push the model's response for that edge.
  task automatic cyc(bit rst, bit ft, bit st, bit hl, int px, int py);
    exp_t e;
    bit   sc;
    int   nx;
    @(negedge clk);
    rst_n      = rst;
    frame_tick = ft;
    start      = st;
    halt       = hl;
    pixel_x    = 10'(px);
    pixel_y    = 10'(py);
    if (!rst) begin
      #1;
      chk("async_rst_color", pipe_color, 1'b0);
      chk("async_rst_running", running, 1'b0);
      m_reset();
      e.color = 1'b0;
      e.score = 1'b0;
      e.run   = 1'b0;
    end else begin
      e.color = m_color(px, py);
      sc = 1'b0;
      if (ms == M_RUN && ft && !st && !hl) begin
        for (int i = 0; i < NP; i++) begin
          nx = mx[i] - SS;
          if (nx <= -PW) begin
            mx[i] = nx + NP * SP;
            mg[i] = GMIN + int'(ml[7:0]);
          end else begin
            if (mx[i] + PW >= BX && nx + PW < BX) sc = 1'b1;
            mx[i] = nx;
          end
        end
      end
      case (ms)
        M_IDLE:    if (st && !hl) ms = M_RESTART;
        M_RESTART: begin m_load(); ms = M_RUN; end
        M_RUN:     if (hl) ms = M_HALT;
        M_HALT:    if (st && !hl) ms = M_RESTART;
        default:   ms = M_IDLE;
      endcase
      ml = ml[0] ? ((ml >> 1) ^ 16'hB400) : (ml >> 1);
      e.score = sc;
      e.run   = (ms == M_RUN);
    end
    sb.push_back(e);
  endtask

  task automatic frame(int npix, bit st, bit hl);
    int px, py;
    repeat (npix) begin
      rnd_pix(px, py);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, px, py);
    end
    rnd_pix(px, py);
    cyc(1'b1, 1'b1, st, hl, px, py);
  endtask

  // Monitor: every edge yields one expected triple from the driver.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pipe_color", pipe_color, e.color);
        chk("score_pulse", score_pulse, e.score);
        chk("running", running, e.run);
      end
    end
  end

  initial begin
    int px, py, g;
    int pxs[6];
    int pys[6];
    bit st, hl;
    pxs = '{120, 120, 120, 120, 160, 107};
    pys = '{100, 200, 299, 300, 100, 100};
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; halt = 1'b0;
    pixel_x = '0; pixel_y = '0;
    m_reset();

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (4) begin rnd_pix(px, py); cyc(1'b1, 1'b0, 1'b0, 1'b0, px, py); end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 100, 100);
    frame(3, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b1, 1'b0, 100, 100);
    repeat (266) frame(3, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, pxs[k], pys[k]);

    repeat (80) frame(3, 1'b0, 1'b0);
    g = mg[0];
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 610, g - 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 610, g);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 610, g + GH - 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 610, g + GH);

    repeat (10) frame(3, 1'b0, 1'b0);
    frame(2, 1'b0, 1'b1);
    repeat (10) frame(3, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 300, 300);
    repeat (20) frame(2, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 610, 10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 610, 10);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 610, 10);

    repeat (5) frame(3, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 50, 50);
    repeat (30) frame(3, 1'b0, 1'b0);

    repeat (300) begin
      hl = (ms == M_RUN) && ($urandom_range(0, 39) == 0);
      st = !hl && (ms != M_RUN) && ($urandom_range(0, 9) == 0);
      frame(3, st, hl);
    end

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
